// File: rtl/rider_steer_ctrl.sv
// Rider-presence and steering-enable controller for a self-balancing platform.
// It weighs the left/right load cells, waits for a balanced mount, and debounces step-off.
module rider_steer_ctrl #(
  parameter int unsigned LC_W         = 12,
  parameter int unsigned MIN_RIDER_WT = 12'h200,
  parameter int unsigned HYST         = 12'h040,
  parameter int unsigned SETTLE_CNT   = 65_000_000,
  parameter int unsigned STEPOFF_CNT  = 2_500_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LC_W-1:0] lft_ld,
  input  logic [LC_W-1:0] rght_ld,
  input  logic            ld_vld,
  output logic            en_steer,
  output logic            rider_off,
  output logic [1:0]      state_o
);

  localparam int unsigned SUM_W = LC_W + 1;
  localparam int unsigned CMP_W = LC_W + 5;
  localparam int unsigned TMR_W = $clog2(SETTLE_CNT);
  localparam int unsigned DB_W  = $clog2(STEPOFF_CNT);

  localparam logic [SUM_W-1:0] HI_TH    = SUM_W'(MIN_RIDER_WT + HYST);
  localparam logic [SUM_W-1:0] LO_TH    = SUM_W'(MIN_RIDER_WT - HYST);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SETTLE_CNT - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(STEPOFF_CNT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BAL = 2'd1,
    STEER    = 2'd2,
    STEP_OFF = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LC_W-1:0]   lft_q, rght_q;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [DB_W-1:0]   db_q, db_d;

  logic [SUM_W-1:0]  sum;
  logic [LC_W-1:0]   diff;
  logic [CMP_W-1:0]  sum_x, diff_x;
  logic              sum_gt_min, sum_lt_min;
  logic              diff_gt_1_4, diff_gt_15_16;
  logic              tmr_full, db_full, tmr_clr;

  // Every decision is made from the registered samples, one cycle behind ld_vld.
  always_comb begin
    sum           = SUM_W'(lft_q) + SUM_W'(rght_q);
    diff          = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
    sum_x         = CMP_W'(sum);
    diff_x        = CMP_W'(diff);
    sum_gt_min    = (sum > HI_TH);
    sum_lt_min    = (sum < LO_TH);
    diff_gt_1_4   = ((diff_x << 2) > sum_x);
    diff_gt_15_16 = ((diff_x << 4) > ((sum_x << 4) - sum_x));
    tmr_full      = (tmr_q == TMR_LAST);
    db_full       = (db_q == DB_LAST);
  end

  // Loss of weight outranks every balance condition in every state.
  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sum_gt_min) begin
          tmr_clr = 1'b1;
          state_d = WAIT_BAL;
        end
      end
      WAIT_BAL: begin
        if (sum_lt_min)       state_d = IDLE;
        else if (diff_gt_1_4) tmr_clr = 1'b1;
        else if (tmr_full)    state_d = STEER;
      end
      STEER: begin
        if (sum_lt_min)         state_d = IDLE;
        else if (diff_gt_15_16) state_d = STEP_OFF;
      end
      STEP_OFF: begin
        if (sum_lt_min)          state_d = IDLE;
        else if (!diff_gt_15_16) state_d = STEER;
        else if (db_full) begin
          tmr_clr = 1'b1;
          state_d = WAIT_BAL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The debounce count is held at zero outside STEP_OFF, so each entry starts fresh.
  always_comb begin
    tmr_d = tmr_clr ? '0 : (tmr_full ? tmr_q : tmr_q + TMR_W'(1));
    if (state_q != STEP_OFF) db_d = '0;
    else                     db_d = db_full ? db_q : db_q + DB_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lft_q   <= '0;
      rght_q  <= '0;
      tmr_q   <= '0;
      db_q    <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      db_q    <= db_d;
      if (ld_vld) begin
        lft_q  <= lft_ld;
        rght_q <= rght_ld;
      end
    end
  end

  assign en_steer  = (state_q == STEER) || (state_q == STEP_OFF);
  assign rider_off = (state_q == IDLE) || sum_lt_min;
  assign state_o   = state_q;

endmodule

// File: doc/rider_steer_ctrl.md
RIDER_STEER_CTRL -- requirements
Module: rider_steer_ctrl

Interface
REQ-001 Parameter LC_W, default 12, load-cell sample width (unsigned).
REQ-002 Parameter MIN_RIDER_WT, default 12'h200, minimum rider weight, in load-cell counts.
REQ-003 Parameter HYST, default 12'h040, hysteresis band, with MIN_RIDER_WT >= HYST.
REQ-004 Parameter SETTLE_CNT, default 65_000_000 (1.3 s at 50 MHz), number of balance-settle cycles, >= 2.
REQ-005 Parameter STEPOFF_CNT, default 2_500_000 (50 ms), step-off debounce cycles, >= 2.
REQ-006 clk  input  1  system clock; one clock domain; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 lft_ld  input  LC_W  left load-cell sample.
REQ-009 rght_ld  input  LC_W  right load-cell sample.
REQ-010 ld_vld  input  1  one-cycle strobe; lft_ld/rght_ld are valid in this cycle.
REQ-011 en_steer  output  1  steering enable to balance control.
REQ-012 rider_off  output  1  no rider present.
REQ-013 state_o  output  2  current state: IDLE=0, WAIT_BAL=1, STEER=2, STEP_OFF=3.

Function
REQ-014 Samples: on each cycle with ld_vld=1, capture lft_ld/rght_ld into internal registers; otherwise hold the registered values.
REQ-015 sum = lft + rght at LC_W+1 bits with no overflow; diff = |lft - rght| at LC_W bits.
REQ-016 sum_gt_min = (sum > MIN_RIDER_WT+HYST); sum_lt_min = (sum < MIN_RIDER_WT-HYST); both are 0 inside the band.
REQ-017 diff_gt_1_4 = (4*diff > sum); diff_gt_15_16 = (16*diff > 15*sum); both computed at LC_W+5 bits, exact, no truncation.
REQ-018 All comparisons use the registered samples, so a new sample affects the FSM one cycle after its ld_vld.
REQ-019 Settle timer: free-running up-counter of width clog2(SETTLE_CNT); tmr_full = (count == SETTLE_CNT-1); saturates at SETTLE_CNT-1; clear forces 0 next cycle.
REQ-020 Debounce counter: counts only in STEP_OFF; cleared on every entry to STEP_OFF; db_full = (count == STEPOFF_CNT-1).
REQ-021 IDLE: if sum_gt_min, clear timer and go to WAIT_BAL; else stay.
REQ-022 WAIT_BAL, priority order: sum_lt_min -> IDLE; else diff_gt_1_4 -> clear timer, stay; else tmr_full -> STEER; else stay.
REQ-023 STEER, priority order: sum_lt_min -> IDLE; else diff_gt_15_16 -> STEP_OFF; else stay.
REQ-024 STEP_OFF, priority order: sum_lt_min -> IDLE; else !diff_gt_15_16 -> STEER (glitch rejected); else db_full -> clear timer, go to WAIT_BAL; else stay.
REQ-025 en_steer = 1 in STEER and STEP_OFF (steering holds during debounce); 0 otherwise.
REQ-026 rider_off = (state==IDLE) | sum_lt_min; combinational from the registered state and samples.
REQ-027 Illegal or unreachable encodings do not exist with 2 bits; the default branch returns to IDLE.
REQ-028 Simultaneous sum_lt_min and any diff condition: sum_lt_min wins in every state.
REQ-029 ld_vld held 0 indefinitely: the FSM keeps evaluating the last captured samples; timers keep running.

Reset
REQ-030 While rst=1, asynchronously: state=IDLE, sample registers=0, timer=0, debounce counter=0.
REQ-031 Outputs under reset: en_steer=0, rider_off=1, state_o=0.
REQ-032 Reset asserted mid-operation (any state) returns to IDLE immediately, with no extra cycle.
REQ-033 After rst deasserts, the first state change is possible on the first rising edge.

Verification (LC_W=12, MIN=0x200, HYST=0x40, SETTLE_CNT=16, STEPOFF_CNT=4)
REQ-034 Mount: lft=rght=0x180 (sum 0x300), balanced -> WAIT_BAL, then en_steer=1 exactly 16 cycles after timer clear; rider_off=0 throughout.
REQ-035 Hysteresis: sum=0x1E0 and sum=0x230 -> no state change, rider_off stays as before; sum=0x1B0 from STEER -> IDLE next cycle, en_steer=0.
REQ-036 Unbalanced: lft=0x280, rght=0x080 (4*diff=0x800 > 0x300) held -> timer repeatedly cleared, never STEER; once balanced, STEER after 16 cycles.
REQ-037 Step-off glitch: in STEER, lft=0x300, rght=0x008 for 2 cycles, then balanced -> STEP_OFF then STEER, en_steer never drops; held >= 4 cycles -> WAIT_BAL, en_steer=0.
REQ-038 Simultaneous: in STEP_OFF, sum drops to 0x100 with diff still large -> IDLE, not WAIT_BAL; rider_off=1.
REQ-039 Async reset: assert rst between clock edges while in STEER -> en_steer=0, rider_off=1, state_o=0 before the next edge.
